// File: rtl/dado_lanzador.sv
// Die roller: synchronizes and debounces a push-button, spins a 1..6 counter,
// and on release hands the captured face to the face register with a one-cycle write strobe.
module dado_lanzador #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       boton_i,
    output logic [2:0] face_o,
    output logic       valid_o,
    output logic       rolling_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       roll_q;
    logic [2:0]       roll_d;
    state_t           state_q;
    logic [2:0]       face_q;
    logic             valid_q;
    logic             rolling_q;

    // Debounce next state: the level only flips after DEBOUNCE_CYCLES straight disagreements.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Roll counter next value: wraps 6 -> 1, never visits 0 or 7.
    always_comb begin
        if (roll_q == 3'd6) begin
            roll_d = 3'd1;
        end else begin
            roll_d = roll_q + 3'd1;
        end
    end

    // Synchronizer, debouncer and free-running roll counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
            roll_q <= 3'd1;
        end else begin
            s1_q   <= boton_i;
            s2_q   <= s1_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
            roll_q <= roll_d;
        end
    end

    // Roll FSM with registered outputs; face is captured on the ROLLING -> EMIT edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            face_q    <= 3'd1;
            valid_q   <= 1'b0;
            rolling_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (deb_q) begin
                        state_q   <= ST_ROLLING;
                        rolling_q <= 1'b1;
                    end else begin
                        rolling_q <= 1'b0;
                    end
                end
                ST_ROLLING: begin
                    if (!deb_q) begin
                        state_q   <= ST_EMIT;
                        face_q    <= roll_q;
                        valid_q   <= 1'b1;
                        rolling_q <= 1'b0;
                    end else begin
                        valid_q   <= 1'b0;
                        rolling_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    state_q   <= ST_IDLE;
                    valid_q   <= 1'b0;
                    rolling_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    valid_q   <= 1'b0;
                    rolling_q <= 1'b0;
                end
            endcase
        end
    end

    assign face_o    = face_q;
    assign valid_o   = valid_q;
    assign rolling_o = rolling_q;

endmodule

// File: tb/tb_dado_lanzador.sv
// Bench for dado_lanzador: directed and random button sequences checked each cycle
// against a window-based debounce model and an edge-count roll model.
module tb_dado_lanzador;

    logic       clk = 1'b0;
    logic       rst;
    logic       boton;
    logic [2:0] face;
    logic       valid;
    logic       rolling;

    always #5 clk = ~clk;

    dado_lanzador #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .boton_i   (boton),
        .face_o    (face),
        .valid_o   (valid),
        .rolling_o (rolling)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit hist[$];
    int n_edges;
    bit m_deb;
    bit m_rolling;
    bit m_valid;
    int m_face;

    // observed-behaviour bookkeeping
    int  dut_valid_cnt;
    int  dut_roll_entries;
    bit  rolling_prev;
    int  rise_at;
    int  valid_at;
    int  captured;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        // five pre-reset samples of 0 stand in for the cleared sync flops
        for (int i = 0; i < 5; i++) hist.push_back(1'b0);
        n_edges   = 0;
        m_deb     = 1'b0;
        m_rolling = 1'b0;
        m_valid   = 1'b0;
        m_face    = 1;
    endtask

    task automatic model_edge(input bit b);
        bit prev_deb;
        bit all_diff;
        int last;
        prev_deb = m_deb;
        all_diff = 1'b1;
        hist.push_back(b);
        n_edges++;
        last = hist.size() - 1;
        // button seen 2..5 edges ago (2-flop delay, 4-sample window) must all oppose deb
        for (int i = 2; i <= 5; i++) if (hist[last - i] == m_deb) all_diff = 1'b0;
        if (all_diff) m_deb = ~m_deb;
        if (m_valid) begin
            m_valid = 1'b0;
        end else if (!m_rolling) begin
            if (prev_deb) m_rolling = 1'b1;
        end else if (!prev_deb) begin
            m_rolling = 1'b0;
            m_valid   = 1'b1;
            m_face    = ((n_edges - 1) % 6) + 1;
        end
    endtask

    task automatic step(input bit r, input bit b);
        rst   = r;
        boton = b;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(b);
        #1;
        chk("face", 32'(face), 32'(m_face));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("rolling", 32'(rolling), 32'(m_rolling));
        if (valid === 1'b1) begin
            dut_valid_cnt++;
            valid_at = n_edges;
            captured = int'(face);
        end
        if (rolling === 1'b1 && !rolling_prev) begin
            dut_roll_entries++;
            rise_at = n_edges;
        end
        rolling_prev = (rolling === 1'b1);
    endtask

    task automatic clear_obs();
        dut_valid_cnt    = 0;
        dut_roll_entries = 0;
        rise_at          = -1;
        valid_at         = -1;
        captured         = 0;
    endtask

    initial begin
        int press_edge;
        int rel_edge;
        int len;
        rst          = 1'b1;
        boton        = 1'b0;
        rolling_prev = 1'b0;
        clear_obs();
        model_reset();

        // reset, then 50 idle cycles
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("reset_face", 32'(face), 32'd1);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_rolling", 32'(rolling), 32'd0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        chk("idle_no_valid", 32'(dut_valid_cnt), 32'd0);

        // 3-cycle glitch must be discarded
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("glitch_no_roll", 32'(dut_roll_entries), 32'd0);
        chk("glitch_no_valid", 32'(dut_valid_cnt), 32'd0);

        // clean 40-cycle press
        clear_obs();
        press_edge = n_edges + 1;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        rel_edge = n_edges + 1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("press_latency", 32'(rise_at - press_edge), 32'd6);
        chk("release_latency", 32'(valid_at - rel_edge), 32'd6);
        chk("clean_one_pulse", 32'(dut_valid_cnt), 32'd1);
        chk("clean_face_val", 32'(captured), 32'(((valid_at - 1) % 6) + 1));
        chk("clean_face_range", 32'(captured >= 1 && captured <= 6), 32'd1);

        // bouncy press and bouncy release
        clear_obs();
        for (int i = 0; i < 10; i++) step(1'b0, ((i / 2) % 2) == 0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, ((i / 2) % 2) == 1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        chk("bouncy_one_roll", 32'(dut_roll_entries), 32'd1);
        chk("bouncy_one_valid", 32'(dut_valid_cnt), 32'd1);

        // press length sweep from a fixed offset after reset
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0);
            clear_obs();
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
            for (int i = 0; i < 20 + k; i++) step(1'b0, 1'b1);
            for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
            chk("sweep_face", 32'(captured), 32'(((29 + k) % 6) + 1));
            chk("sweep_one_valid", 32'(dut_valid_cnt), 32'd1);
        end

        // reset in the middle of a roll, button released shortly afterwards
        clear_obs();
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        chk("midroll_rolling", 32'(rolling), 32'd1);
        step(1'b1, 1'b1);
        chk("midroll_rst_face", 32'(face), 32'd1);
        chk("midroll_rst_rolling", 32'(rolling), 32'd0);
        clear_obs();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("midroll_no_valid", 32'(dut_valid_cnt), 32'd0);
        chk("midroll_no_roll", 32'(dut_roll_entries), 32'd0);

        // random noisy presses with occasional resets
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 7) == 0) step(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) step(1'b0, 1'($urandom_range(0, 1)));
            len = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) step(1'b0, 1'b1);
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) step(1'b0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(8, 20)); i++) step(1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
